// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
package arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
  localparam int HOLD_W = 8;
endpackage

// File: rtl/rr_prio_sel.sv
// Combinational round-robin selector: lowest request at or above ptr, else lowest overall.
module rr_prio_sel #(
  parameter int OUT_SIZE = 4,
  parameter int IN_SIZE  = 1 << OUT_SIZE
) (
  input  logic [IN_SIZE-1:0]  req,
  input  logic [OUT_SIZE-1:0] ptr,
  output logic [OUT_SIZE-1:0] idx,
  output logic                found
);
  logic [IN_SIZE-1:0]  upper_mask;
  logic [IN_SIZE-1:0]  masked_req;
  logic [OUT_SIZE-1:0] hi_idx;
  logic [OUT_SIZE-1:0] lo_idx;
  logic                hi_found;
  logic                lo_found;

  for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_mask
    assign upper_mask[gi] = (gi >= 32'(ptr));
  end

  assign masked_req = req & upper_mask;

  // Scan downwards so the last hit is the lowest set index.
  always_comb begin
    hi_idx   = '0;
    hi_found = 1'b0;
    lo_idx   = '0;
    lo_found = 1'b0;
    for (int i = IN_SIZE - 1; i >= 0; i--) begin
      if (masked_req[i]) begin
        hi_idx   = OUT_SIZE'(i);
        hi_found = 1'b1;
      end
      if (req[i]) begin
        lo_idx   = OUT_SIZE'(i);
        lo_found = 1'b1;
      end
    end
  end

  assign idx   = hi_found ? hi_idx : lo_idx;
  assign found = lo_found;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold-time limit, one-cycle grant latency and an idle bubble after each release.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int OUT_SIZE = 4,
  parameter int IN_SIZE  = 1 << OUT_SIZE,
  parameter int MAX_HOLD = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [IN_SIZE-1:0]  req,
  output logic [IN_SIZE-1:0]  gnt,
  output logic [OUT_SIZE-1:0] gnt_idx,
  output logic                gnt_valid,
  output logic                timeout
);
  arb_state_t          state_reg, state_next;
  logic [IN_SIZE-1:0]  gnt_reg, gnt_next;
  logic [OUT_SIZE-1:0] gnt_idx_reg, gnt_idx_next;
  logic [OUT_SIZE-1:0] ptr_reg, ptr_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next, hold_inc;
  logic                timeout_reg, timeout_next;

  logic [OUT_SIZE-1:0] sel_idx;
  logic                sel_found;
  logic [IN_SIZE-1:0]  sel_onehot;

  rr_prio_sel #(.OUT_SIZE(OUT_SIZE), .IN_SIZE(IN_SIZE)) u_sel (
    .req   (req),
    .ptr   (ptr_reg),
    .idx   (sel_idx),
    .found (sel_found)
  );

  for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_dec
    assign sel_onehot[gi] = (sel_idx == OUT_SIZE'(gi));
  end

  assign hold_inc = (hold_reg == '1) ? hold_reg : hold_reg + HOLD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_idx_reg <= '0;
      ptr_reg     <= '0;
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_idx_reg <= gnt_idx_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_idx_next = gnt_idx_reg;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && sel_found) begin
          state_next   = GRANT;
          gnt_next     = sel_onehot;
          gnt_idx_next = sel_idx;
          ptr_next     = (sel_idx == OUT_SIZE'(IN_SIZE - 1)) ? '0 : sel_idx + OUT_SIZE'(1);
          hold_next    = '0;
        end
      end
      GRANT: begin
        hold_next = hold_inc;
        // A voluntary release wins over a coinciding hold-limit expiry.
        if (!req[gnt_idx_reg]) begin
          state_next   = IDLE;
          gnt_next     = '0;
          gnt_idx_next = '0;
        end else if (hold_inc >= HOLD_W'(MAX_HOLD)) begin
          state_next   = IDLE;
          gnt_next     = '0;
          gnt_idx_next = '0;
          timeout_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = gnt_idx_reg;
  assign gnt_valid = |gnt_reg;
  assign timeout   = timeout_reg;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with hand-computed expectations.
module tb_rr_arbiter;
  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int n_checks;
  int n_errors;
  int cycles;

  rr_arbiter #(.OUT_SIZE(4), .IN_SIZE(16), .MAX_HOLD(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b1;
    enable = 1'b0;
    req    = '0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;

    // First grant from ptr=0
    enable = 1'b1;
    req    = 16'h0005;
    step();
    check("g0_gnt", 32'(gnt), 32'h0001);
    check("g0_idx", 32'(gnt_idx), 32'h0);
    check("g0_valid", 32'(gnt_valid), 32'h1);
    check("g0_ptr", 32'(dut.ptr_reg), 32'h1);
    step();
    step();
    check("g0_hold", 32'(gnt), 32'h0001);

    // Release of req[0] with one idle bubble, then req[2]
    req = 16'h0004;
    step();
    check("rel0_gnt", 32'(gnt), 32'h0);
    check("rel0_valid", 32'(gnt_valid), 32'h0);
    check("rel0_timeout", 32'(timeout), 32'h0);
    step();
    check("g2_gnt", 32'(gnt), 32'h0004);
    check("g2_idx", 32'(gnt_idx), 32'h2);
    req = 16'h0000;
    step();
    step();

    // Wrap-around: grant 14 so ptr becomes 15
    req = 16'h4000;
    step();
    check("g14_idx", 32'(gnt_idx), 32'he);
    req = 16'h0000;
    step();
    req = 16'h8001;
    step();
    check("wrap_idx15", 32'(gnt_idx), 32'hf);
    check("wrap_ptr0", 32'(dut.ptr_reg), 32'h0);
    req = 16'h0001;
    step();
    check("wrap_rel", 32'(gnt_valid), 32'h0);
    step();
    check("wrap_idx0", 32'(gnt_idx), 32'h0);
    req = 16'h0000;
    step();
    step();

    // Hold limit: req[3] stays high, grant must drop after 15 cycles
    req = 16'h0008;
    step();
    cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (gnt !== 16'h0008) break;
      cycles++;
      step();
    end
    check("to_cycles", 32'(cycles), 32'd15);
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_gnt", 32'(gnt), 32'h0);
    req = 16'h0108;
    step();
    check("to_pulse_end", 32'(timeout), 32'h0);
    check("after_to_idx", 32'(gnt_idx), 32'h8);
    req = 16'h0000;
    step();
    step();

    // Release coinciding with hold-limit edge: no timeout
    req = 16'h0008;
    step();
    check("co_idx", 32'(gnt_idx), 32'h3);
    for (int i = 0; i < 14; i++) step();
    check("co_still", 32'(gnt), 32'h0008);
    req = 16'h0000;
    step();
    check("co_gnt", 32'(gnt), 32'h0);
    check("co_timeout", 32'(timeout), 32'h0);
    step();

    // enable low in IDLE blocks grants
    enable = 1'b0;
    req    = 16'hFFFF;
    step();
    step();
    step();
    check("en0_valid", 32'(gnt_valid), 32'h0);
    enable = 1'b1;
    step();
    check("en1_idx", 32'(gnt_idx), 32'h4);
    enable = 1'b0;
    req    = 16'h0010;
    step();
    step();
    check("en0_hold", 32'(gnt), 32'h0010);
    req = 16'h0000;
    step();
    check("en0_rel", 32'(gnt_valid), 32'h0);
    step();

    // Asynchronous reset mid-grant
    enable = 1'b1;
    req    = 16'h0010;
    step();
    check("pre_rst_gnt", 32'(gnt), 32'h0010);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_valid", 32'(gnt_valid), 32'h0);
    check("arst_timeout", 32'(timeout), 32'h0);
    step();
    rst = 1'b0;
    req = 16'h0006;
    step();
    check("post_rst_idx", 32'(gnt_idx), 32'h1);
    check("post_rst_gnt", 32'(gnt), 32'h0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
